// File: rtl/csel_pkg.sv
// Shared types and helpers for the pipelined carry-select adder/subtractor.
package csel_pkg;

    // Operation select: add or subtract.
    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Legal geometry: WIDTH splits into whole groups, groups split evenly across stages.
    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned block,
                                     input int unsigned stages);
        bit ok;
        ok = 1'b1;
        if (block == 0 || stages == 0 || width == 0) begin
            ok = 1'b0;
        end else if ((width % block) != 0) begin
            ok = 1'b0;
        end else if (stages > (width / block) || ((width / block) % stages) != 0) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/csel_group.sv
// One carry-select group: two ripple sums (carry-in 0 and 1) and a select mux.
module csel_group #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_in,
    output logic [BLOCK-1:0] s,
    output logic             c_out
);

    logic [BLOCK:0]   k0;
    logic [BLOCK:0]   k1;
    logic [BLOCK-1:0] s0;
    logic [BLOCK-1:0] s1;

    // Speculative ripple sums for both possible incoming carries.
    always_comb begin
        k0    = '0;
        k1    = '0;
        s0    = '0;
        s1    = '0;
        k0[0] = 1'b0;
        k1[0] = 1'b1;
        for (int i = 0; i < int'(BLOCK); i++) begin
            s0[i]   = a[i] ^ b[i] ^ k0[i];
            k0[i+1] = (a[i] & b[i]) | (k0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ k1[i];
            k1[i+1] = (a[i] & b[i]) | (k1[i] & (a[i] ^ b[i]));
        end
    end

    // The real incoming carry picks one candidate.
    assign s     = c_in ? s1 : s0;
    assign c_out = c_in ? k1[BLOCK] : k0[BLOCK];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
module pipelined_csel_adder
    import csel_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  mode_e            mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NBLK = WIDTH / BLOCK;
    localparam int unsigned BPS  = NBLK / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if (!params_ok(WIDTH, BLOCK, STAGES)) begin : g_param_err
        $error("pipelined_csel_adder: illegal WIDTH/BLOCK/STAGES combination");
    end

    // Per-stage payload: operands (b already inverted for SUB), partial sum, carry into next stage.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
    } stage_t;

    stage_t            st_in [STAGES];
    stage_t            st_nx [STAGES];
    stage_t            st_q  [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;
    logic              ovf_q;
    logic              ovf_d;

    logic [BLOCK-1:0]  gs [NBLK];
    logic [NBLK-1:0]   gc;
    logic [NBLK-1:0]   gci;

    // Stage inputs: stage 0 takes the ports, later stages take the previous register.
    always_comb begin
        for (int s = 0; s < int'(STAGES); s++) begin
            st_in[s] = '0;
        end
        st_in[0].a = a;
        st_in[0].b = (mode == MODE_SUB) ? ~b : b;
        st_in[0].s = '0;
        st_in[0].c = (mode == MODE_SUB) ? 1'b1 : cin;
        for (int s = 1; s < int'(STAGES); s++) begin
            st_in[s] = st_q[s-1];
        end
    end

    // Carry-select groups; the first group of each stage uses that stage's registered carry.
    for (genvar g = 0; g < int'(NBLK); g++) begin : g_grp
        localparam int unsigned STG = g / BPS;
        if ((g % BPS) == 0) begin : g_first
            assign gci[g] = st_in[STG].c;
        end else begin : g_chain
            assign gci[g] = gc[g-1];
        end
        csel_group #(.BLOCK(BLOCK)) u_grp (
            .a     (st_in[STG].a[g*BLOCK +: BLOCK]),
            .b     (st_in[STG].b[g*BLOCK +: BLOCK]),
            .c_in  (gci[g]),
            .s     (gs[g]),
            .c_out (gc[g])
        );
    end

    // Merge each stage's resolved groups into the travelling partial sum; derive final overflow.
    always_comb begin
        ovf_d = 1'b0;
        for (int s = 0; s < int'(STAGES); s++) begin
            st_nx[s] = st_in[s];
        end
        for (int g = 0; g < int'(NBLK); g++) begin
            st_nx[g / BPS].s[g*BLOCK +: BLOCK] = gs[g];
        end
        for (int s = 0; s < int'(STAGES); s++) begin
            st_nx[s].c = gc[s*BPS + BPS - 1];
        end
        ovf_d = (st_in[LAST].a[WIDTH-1] == st_in[LAST].b[WIDTH-1]) &&
                (st_nx[LAST].s[WIDTH-1] != st_in[LAST].a[WIDTH-1]);
    end

    // Advance chain: a stage loads when empty or when its content moves downstream this cycle.
    always_comb begin
        adv       = '0;
        ld        = '0;
        up_v      = '0;
        up_v[0]   = in_valid;
        adv[LAST] = v_q[LAST] && out_ready;
        ld[LAST]  = !v_q[LAST] || adv[LAST];
        for (int s = int'(STAGES) - 2; s >= 0; s--) begin
            adv[s]    = v_q[s] && ld[s+1];
            ld[s]     = !v_q[s] || adv[s];
            up_v[s+1] = v_q[s];
        end
    end

    // Stage registers; payload only updates when a valid operation moves in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            ovf_q <= 1'b0;
            for (int s = 0; s < int'(STAGES); s++) begin
                st_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(STAGES); s++) begin
                if (ld[s]) begin
                    v_q[s] <= up_v[s];
                    if (up_v[s]) begin
                        st_q[s] <= st_nx[s];
                    end
                end
            end
            if (ld[LAST] && up_v[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[LAST];
    assign sum       = st_q[LAST].s;
    assign cout      = st_q[LAST].c;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench for pipelined_csel_adder (WIDTH=16, BLOCK=4, STAGES=2).
module tb_pipelined_csel_adder;
    import csel_pkg::*;

    localparam int unsigned W    = 16;
    localparam int          NRND = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    mode_e        mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    // Expected {cout, ovf, sum} in issue order.
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_csel_adder #(.WIDTH(16), .BLOCK(4), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: plain wide addition with the operand inverted for SUB.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input mode_e m);
        logic [W-1:0] be;
        logic [W:0]   f;
        logic         o;
        be = (m == MODE_SUB) ? ~y : y;
        f  = {1'b0, x} + {1'b0, be} + {16'd0, ((m == MODE_SUB) ? 1'b1 : c)};
        o  = (x[W-1] == be[W-1]) && (f[W-1] != x[W-1]);
        return {f[W], o, f[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'hFFFF;
            1: v = 16'h8000;
            2: v = 16'h7FFF;
            3: v = 16'h0000;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    task automatic drive_idle();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        mode     = MODE_ADD;
    endtask

    // Offer one op, push its expected result on accept, then wait for the output (no checking here).
    task automatic issue_one(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                             input mode_e xm, input logic [W+1:0] expv,
                             output logic [W+1:0] got, output int lat);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = xa;
        b         = xb;
        cin       = xc;
        mode      = xm;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready) exp_q.push_back(expv);
        @(negedge clk);
        drive_idle();
        lat = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            #1;
        end
        got = {cout, ovf, sum};
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [W+1:0] te [3];
        logic [W+1:0] got;
        logic [W+1:0] e;
        int           lat;
        ta[0] = 16'h0001; tb[0] = 16'h0002; te[0] = {1'b0, 1'b0, 16'h0003};
        ta[1] = 16'hFFFF; tb[1] = 16'h0001; te[1] = {1'b1, 1'b0, 16'h0000};
        ta[2] = 16'h7FFF; tb[2] = 16'h0001; te[2] = {1'b0, 1'b1, 16'h8000};
        for (int i = 0; i < 3; i++) begin
            issue_one(ta[i], tb[i], 1'b0, MODE_ADD, te[i], got, lat);
            checks++;
            if (lat != 2) begin errors++; $display("FAIL add_latency[%0d] got=%0d exp=2", i, lat); end
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL add_result[%0d] got=%h exp=<no op accepted>", i, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin errors++; $display("FAIL add_result[%0d] got={c,v,s}=%h exp=%h", i, got, e); end
            end
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        logic [W+1:0] te [2];
        logic [W+1:0] got;
        logic [W+1:0] e;
        int           lat;
        ta[0] = 16'h0005; tb[0] = 16'h0007; te[0] = {1'b0, 1'b0, 16'hFFFE};
        ta[1] = 16'h8000; tb[1] = 16'h0001; te[1] = {1'b1, 1'b1, 16'h7FFF};
        for (int i = 0; i < 2; i++) begin
            issue_one(ta[i], tb[i], 1'b1, MODE_SUB, te[i], got, lat);
            checks++;
            if (lat != 2) begin errors++; $display("FAIL sub_latency[%0d] got=%0d exp=2", i, lat); end
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sub_result[%0d] got=%h exp=<no op accepted>", i, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin errors++; $display("FAIL sub_result[%0d] got={c,v,s}=%h exp=%h", i, got, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int           sent = 0;
        int           rcvd = 0;
        int           stall_left = 0;
        int           ready_low = 0;
        int           cyc = 0;
        bit           stall_started = 1'b0;
        logic         held_v = 1'b0;
        logic [W-1:0] held_s = '0;
        logic [W+1:0] got;
        logic [W+1:0] e;
        out_ready = 1'b1;
        while ((sent < 4 || rcvd < 4) && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (held_v) begin
                checks++;
                if (!out_valid || sum !== held_s) begin
                    errors++; $display("FAIL b2b_hold got=%b/%h exp=1/%h", out_valid, sum, held_s);
                end
            end
            if (!stall_started && out_valid) begin
                stall_started = 1'b1;
                stall_left    = 3;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (sent < 4) begin
                in_valid = 1'b1;
                a        = 16'((sent + 1) * 16);
                b        = 16'(sent + 1);
                cin      = 1'b0;
                mode     = MODE_ADD;
            end else begin
                drive_idle();
            end
            #1;
            held_v = out_valid && !out_ready;
            held_s = sum;
            if (in_valid && !in_ready) ready_low++;
            if (out_valid && out_ready) begin
                got = {cout, ovf, sum};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_result[%0d] got=%h exp=<none outstanding>", rcvd, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL b2b_result[%0d] got=%h exp=%h", rcvd, got, e); end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({2'b00, 16'((sent + 1) * 17)});
                sent++;
            end
        end
        checks++; if (ready_low != 3) begin errors++; $display("FAIL b2b_in_ready_low got=%0d exp=3", ready_low); end
        checks++; if (sent != 4 || rcvd != 4) begin errors++; $display("FAIL b2b_count got=%0d/%0d exp=4/4", sent, rcvd); end
        drive_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_output got=%b exp=0", out_valid); end
        end
    endtask

    task automatic test_random();
        int           sent = 0;
        int           rcvd = 0;
        int           cyc = 0;
        logic         held_v = 1'b0;
        logic [W+1:0] held = '0;
        logic [W+1:0] got;
        logic [W+1:0] e;
        while ((sent < NRND || rcvd < NRND) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            got = {cout, ovf, sum};
            if (held_v) begin
                checks++;
                if (!out_valid || got !== held) begin
                    errors++; $display("FAIL rnd_hold got=%b/%h exp=1/%h", out_valid, got, held);
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            if (sent < NRND && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                a        = rnd_operand();
                b        = rnd_operand();
                cin      = 1'b1;
                mode     = ($urandom_range(0, 1) == 1) ? MODE_SUB : MODE_ADD;
            end else begin
                drive_idle();
            end
            #1;
            held_v = out_valid && !out_ready;
            held   = {cout, ovf, sum};
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_result[%0d] got=%h exp=<none outstanding>", rcvd, held);
                end else begin
                    e = exp_q.pop_front();
                    if (held !== e) begin errors++; $display("FAIL rnd_result[%0d] got=%h exp=%h", rcvd, held, e); end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(a, b, cin, mode));
                sent++;
            end
        end
        drive_idle();
        checks++; if (rcvd != NRND) begin errors++; $display("FAIL rnd_count got=%0d exp=%0d", rcvd, NRND); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h1111;
        b         = 16'h2222;
        cin       = 1'b0;
        mode      = MODE_ADD;
        @(negedge clk);
        a         = 16'h0F0F;
        b         = 16'h0101;
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_inflight got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL midrst_flags got=%b%b exp=00", cout, ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost_output got=%b exp=0", out_valid); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
